// File: rtl/mcu_bridge_pkg.sv
// Shared types and lane helpers for the MCU-to-qword memory bridge.
package mcu_bridge_pkg;

  localparam int unsigned QW_BITS = 64;
  localparam int unsigned LANES   = 8;
  localparam int unsigned OFF_W   = 3;
  localparam int unsigned ADDR_W  = 45;
  localparam int unsigned QADDR_W = ADDR_W - OFF_W;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SIZE_W  = 2;

  typedef enum logic [SIZE_W-1:0] {
    SZ_B = 2'b00,
    SZ_W = 2'b01,
    SZ_D = 2'b10
  } size_e;

  typedef struct packed {
    logic               cmd;
    logic [QADDR_W-1:0] qaddr;
    logic [LANES-1:0]   be;
    logic [QW_BITS-1:0] data;
  } req_t;

  typedef struct packed {
    size_e             size;
    logic [OFF_W-1:0]  off;
  } trk_t;

  localparam int unsigned REQ_W = $bits(req_t);
  localparam int unsigned TRK_W = $bits(trk_t);

  // Encoding 2'b11 behaves as a 32-bit access.
  function automatic size_e to_size(input logic [SIZE_W-1:0] s);
    size_e r;
    case (s)
      2'b00:   r = SZ_B;
      2'b01:   r = SZ_W;
      default: r = SZ_D;
    endcase
    return r;
  endfunction

  function automatic logic [OFF_W-1:0] align_off(input size_e size, input logic [OFF_W-1:0] off);
    logic [OFF_W-1:0] r;
    case (size)
      SZ_W:    r = {off[2:1], 1'b0};
      SZ_D:    r = {off[2], 2'b00};
      default: r = off;
    endcase
    return r;
  endfunction

  function automatic logic [LANES-1:0] byte_en(input size_e size, input logic [OFF_W-1:0] off);
    logic [LANES-1:0] r;
    case (size)
      SZ_B:    r = 8'h01 << off;
      SZ_W:    r = 8'h03 << off;
      default: r = 8'h0F << off;
    endcase
    return r;
  endfunction

  function automatic logic [QW_BITS-1:0] lane_data(input logic [DATA_W-1:0] d, input size_e size,
                                                   input logic [OFF_W-1:0] off);
    logic [DATA_W-1:0] m;
    case (size)
      SZ_B:    m = {24'h0, d[7:0]};
      SZ_W:    m = {16'h0, d[15:0]};
      default: m = d;
    endcase
    return QW_BITS'(m) << {off, 3'b000};
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [QW_BITS-1:0] data, input size_e size,
                                                input logic [OFF_W-1:0] off);
    logic [QW_BITS-1:0] sh;
    logic [DATA_W-1:0]  r;
    sh = data >> {off, 3'b000};
    case (size)
      SZ_B:    r = {24'h0, sh[7:0]};
      SZ_W:    r = {16'h0, sh[15:0]};
      default: r = sh[DATA_W-1:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mcu_bridge_if.sv
// Bridge bus bundle: MCU request/return side plus the qword memory side.
interface mcu_bridge_if;
  import mcu_bridge_pkg::*;

  logic                ACT;
  logic                CMD;
  logic [SIZE_W-1:0]   SIZE;
  logic [ADDR_W-1:0]   ADDRESS;
  logic [DATA_W-1:0]   DTo;
  logic                NEXT;
  logic                DRDY;
  logic [DATA_W-1:0]   DTi;

  logic                MACT;
  logic                MCMD;
  logic [QADDR_W-1:0]  MADDR;
  logic [LANES-1:0]    MBE;
  logic [QW_BITS-1:0]  MDTO;
  logic                MNEXT;
  logic                MDRDY;
  logic [QW_BITS-1:0]  MDTI;

  // Environment view: the microcontroller and the memory bus agent.
  modport master (
    output ACT, CMD, SIZE, ADDRESS, DTo, MNEXT, MDRDY, MDTI,
    input  NEXT, DRDY, DTi, MACT, MCMD, MADDR, MBE, MDTO
  );

  // Bridge view.
  modport slave (
    input  ACT, CMD, SIZE, ADDRESS, DTo, MNEXT, MDRDY, MDTI,
    output NEXT, DRDY, DTi, MACT, MCMD, MADDR, MBE, MDTO
  );
endinterface

// File: rtl/mcu_bridge_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
module mcu_bridge_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; consumers gate the head with empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mcu_mem_bridge.sv
// MCU byte/half/word accesses to 64-bit qword bus with byte enables,
// posted request FIFO and in-order read return tracking.
module mcu_mem_bridge
  import mcu_bridge_pkg::*;
#(
  parameter int unsigned RQ_DEPTH = 4,
  parameter int unsigned RD_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  mcu_bridge_if.slave      bus,
  output logic             ERR,
  output logic             IDLE
);

  localparam int unsigned RQ_CW = $clog2(RQ_DEPTH) + 1;
  localparam int unsigned RD_CW = $clog2(RD_DEPTH) + 1;

  size_e             acc_size;
  logic [OFF_W-1:0]  acc_off;
  req_t              acc_req;
  trk_t              acc_trk;
  req_t              head;
  trk_t              trk_head;

  logic              ready_q;
  logic              accept;
  logic              rq_pop;
  logic              rq_full;
  logic              rq_empty;
  logic [RQ_CW-1:0]  rq_cnt;
  logic              trk_pop;
  logic              trk_full;
  logic              trk_empty;
  logic [RD_CW-1:0]  trk_cnt;
  logic              drdy_q;
  logic [DATA_W-1:0] dti_q;

  // Request formation: align offset per size, build lanes and enables.
  always_comb begin
    acc_size      = to_size(bus.SIZE);
    acc_off       = align_off(acc_size, bus.ADDRESS[OFF_W-1:0]);
    acc_req       = '0;
    acc_req.cmd   = bus.CMD;
    acc_req.qaddr = bus.ADDRESS[ADDR_W-1:OFF_W];
    acc_req.be    = byte_en(acc_size, acc_off);
    acc_req.data  = lane_data(bus.DTo, acc_size, acc_off);
    acc_trk       = '0;
    acc_trk.size  = acc_size;
    acc_trk.off   = acc_off;
  end

  // Tracker holds every accepted read not yet returned, so full means no read slot.
  assign bus.NEXT = ready_q & ~rq_full & (~bus.CMD | ~trk_full);
  assign accept   = bus.ACT & bus.NEXT;
  assign rq_pop   = ~rq_empty & bus.MNEXT;
  assign trk_pop  = bus.MDRDY & ~trk_empty;

  mcu_bridge_fifo #(.WIDTH(REQ_W), .DEPTH(RQ_DEPTH)) u_rq (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (accept),
    .pop   (rq_pop),
    .wdata (acc_req),
    .rdata (head),
    .full  (rq_full),
    .empty (rq_empty),
    .count (rq_cnt)
  );

  mcu_bridge_fifo #(.WIDTH(TRK_W), .DEPTH(RD_DEPTH)) u_trk (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (accept & bus.CMD),
    .pop   (trk_pop),
    .wdata (acc_trk),
    .rdata (trk_head),
    .full  (trk_full),
    .empty (trk_empty),
    .count (trk_cnt)
  );

  assign bus.MACT  = ~rq_empty;
  assign bus.MCMD  = rq_empty ? 1'b0 : head.cmd;
  assign bus.MADDR = rq_empty ? '0 : head.qaddr;
  assign bus.MBE   = rq_empty ? '0 : head.be;
  assign bus.MDTO  = rq_empty ? '0 : head.data;

  assign bus.DRDY  = drdy_q;
  assign bus.DTi   = dti_q;

  // Read return, sticky error and idle status.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ready_q <= 1'b0;
      drdy_q  <= 1'b0;
      dti_q   <= '0;
      ERR     <= 1'b0;
      IDLE    <= 1'b1;
    end else begin
      ready_q <= 1'b1;
      drdy_q  <= trk_pop;
      if (trk_pop) dti_q <= extract(bus.MDTI, trk_head.size, trk_head.off);
      if (bus.MDRDY && trk_empty) ERR <= 1'b1;
      IDLE    <= (rq_cnt == '0) && (trk_cnt == '0);
    end
  end

endmodule

// File: tb/tb_mcu_mem_bridge.sv
// Directed self-checking bench for mcu_mem_bridge.
module tb_mcu_mem_bridge;

  logic clk;
  logic rst_n;
  logic err;
  logic idle;
  int   n_checks;
  int   n_fail;

  mcu_bridge_if bus_i ();

  mcu_mem_bridge #(.RQ_DEPTH(4), .RD_DEPTH(4)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus_i),
    .ERR   (err),
    .IDLE  (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string p);
    check_eq({p, "_next"}, 64'(bus_i.NEXT), 64'h0);
    check_eq({p, "_drdy"}, 64'(bus_i.DRDY), 64'h0);
    check_eq({p, "_dti"},  64'(bus_i.DTi),  64'h0);
    check_eq({p, "_mact"}, 64'(bus_i.MACT), 64'h0);
    check_eq({p, "_mcmd"}, 64'(bus_i.MCMD), 64'h0);
    check_eq({p, "_maddr"}, 64'(bus_i.MADDR), 64'h0);
    check_eq({p, "_mbe"},  64'(bus_i.MBE),  64'h0);
    check_eq({p, "_mdto"}, bus_i.MDTO,      64'h0);
    check_eq({p, "_err"},  64'(err),        64'h0);
    check_eq({p, "_idle"}, 64'(idle),       64'h1);
  endtask

  task automatic check_head(input string p, input logic cmd, input logic [41:0] qaddr,
                            input logic [7:0] be, input logic [63:0] data, input logic chk_data);
    check_eq({p, "_mact"},  64'(bus_i.MACT),  64'h1);
    check_eq({p, "_mcmd"},  64'(bus_i.MCMD),  64'(cmd));
    check_eq({p, "_maddr"}, 64'(bus_i.MADDR), 64'(qaddr));
    check_eq({p, "_mbe"},   64'(bus_i.MBE),   64'(be));
    if (chk_data) check_eq({p, "_mdto"}, bus_i.MDTO, data);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus_i.ACT = 1'b0; bus_i.CMD = 1'b0; bus_i.SIZE = 2'b00;
    bus_i.ADDRESS = '0; bus_i.DTo = '0;
    bus_i.MNEXT = 1'b0; bus_i.MDRDY = 1'b0; bus_i.MDTI = '0;
    step(); step();
    check_reset("rst0");
    rst_n = 1'b1;
    step(); step();

    // Byte write at offset 5, upper DTo bits must not leak into other lanes
    bus_i.ADDRESS = 45'h0ABC_DEF0_1005; bus_i.ACT = 1'b1; bus_i.CMD = 1'b0;
    bus_i.SIZE = 2'b00; bus_i.DTo = 32'hFFFF_FFA5;
    #1;
    check_eq("wb_next", 64'(bus_i.NEXT), 64'h1);
    check_eq("wb_mact_pre", 64'(bus_i.MACT), 64'h0);
    step();
    bus_i.ACT = 1'b0;
    #1;
    check_head("wb", 1'b0, 42'h157_9BDE_0200, 8'h20, 64'h0000_A500_0000_0000, 1'b1);
    bus_i.MNEXT = 1'b1;
    step();
    bus_i.MNEXT = 1'b0;
    #1;
    check_eq("wb_mact_post", 64'(bus_i.MACT), 64'h0);
    check_eq("wb_idle_busy", 64'(idle), 64'h0);
    step();
    check_eq("wb_idle", 64'(idle), 64'h1);

    // 16-bit read at offset 6
    bus_i.ADDRESS = 45'h106; bus_i.ACT = 1'b1; bus_i.CMD = 1'b1; bus_i.SIZE = 2'b01;
    step();
    bus_i.ACT = 1'b0;
    #1;
    check_head("r16", 1'b1, 42'h20, 8'hC0, 64'h0, 1'b0);
    bus_i.MNEXT = 1'b1;
    step();
    bus_i.MNEXT = 1'b0;
    bus_i.MDRDY = 1'b1; bus_i.MDTI = 64'h1234_5678_9ABC_DEF0;
    #1;
    check_eq("r16_drdy_early", 64'(bus_i.DRDY), 64'h0);
    step();
    bus_i.MDRDY = 1'b0;
    #1;
    check_eq("r16_drdy", 64'(bus_i.DRDY), 64'h1);
    check_eq("r16_dti", 64'(bus_i.DTi), 64'h0000_1234);
    step();
    check_eq("r16_drdy_pulse", 64'(bus_i.DRDY), 64'h0);
    check_eq("r16_dti_hold", 64'(bus_i.DTi), 64'h0000_1234);

    // Backpressure: fill request FIFO with 32-bit writes
    bus_i.ACT = 1'b1; bus_i.CMD = 1'b0; bus_i.SIZE = 2'b10;
    for (int i = 0; i < 4; i++) begin
      bus_i.ADDRESS = 45'h200 + 45'(i * 8);
      bus_i.DTo     = 32'hC0DE_0000 + 32'(i);
      #1;
      check_eq("bp_next", 64'(bus_i.NEXT), 64'h1);
      step();
    end
    check_eq("bp_full_next", 64'(bus_i.NEXT), 64'h0);
    check_eq("bp_idle", 64'(idle), 64'h0);
    bus_i.ACT = 1'b0; bus_i.MNEXT = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_head("bp", 1'b0, 42'h40 + 42'(i), 8'h0F, 64'(32'hC0DE_0000 + 32'(i)), 1'b1);
      step();
      if (i == 0) check_eq("bp_reopen", 64'(bus_i.NEXT), 64'h1);
    end
    bus_i.MNEXT = 1'b0;
    #1;
    check_eq("bp_drained", 64'(bus_i.MACT), 64'h0);

    // Read limit: four reads outstanding
    bus_i.MNEXT = 1'b1; bus_i.ACT = 1'b1; bus_i.CMD = 1'b1; bus_i.SIZE = 2'b10;
    for (int i = 0; i < 4; i++) begin
      bus_i.ADDRESS = 45'h300 + 45'(i * 8);
      #1;
      check_eq("rl_next", 64'(bus_i.NEXT), 64'h1);
      step();
    end
    check_eq("rl_read_blocked", 64'(bus_i.NEXT), 64'h0);
    bus_i.ACT = 1'b0; bus_i.CMD = 1'b0;
    #1;
    check_eq("rl_write_ok", 64'(bus_i.NEXT), 64'h1);
    bus_i.CMD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_i.MDTI  = {32'hAAAA_0000 + 32'(i), 32'h5555_0000 + 32'(i)};
      bus_i.MDRDY = 1'b1;
      step();
      check_eq("rl_drdy", 64'(bus_i.DRDY), 64'h1);
      check_eq("rl_dti", 64'(bus_i.DTi), 64'(32'h5555_0000 + 32'(i)));
      if (i == 0) check_eq("rl_reopen", 64'(bus_i.NEXT), 64'h1);
    end
    bus_i.MDRDY = 1'b0;
    step();
    check_eq("rl_drdy_end", 64'(bus_i.DRDY), 64'h0);
    bus_i.MNEXT = 1'b0;

    // Ordering: write then read of the same word, SIZE=11 acts as 32-bit
    bus_i.ACT = 1'b1; bus_i.CMD = 1'b0; bus_i.SIZE = 2'b10;
    bus_i.ADDRESS = 45'h404; bus_i.DTo = 32'h1122_3344;
    step();
    bus_i.CMD = 1'b1; bus_i.SIZE = 2'b11;
    step();
    bus_i.ACT = 1'b0;
    #1;
    check_head("ord_w", 1'b0, 42'h80, 8'hF0, 64'h1122_3344_0000_0000, 1'b1);
    bus_i.MNEXT = 1'b1;
    step();
    check_head("ord_r", 1'b1, 42'h80, 8'hF0, 64'h0, 1'b0);
    step();
    bus_i.MNEXT = 1'b0;
    #1;
    check_eq("ord_empty", 64'(bus_i.MACT), 64'h0);
    bus_i.MDRDY = 1'b1; bus_i.MDTI = 64'h1122_3344_0000_0000;
    step();
    bus_i.MDRDY = 1'b0;
    #1;
    check_eq("ord_drdy", 64'(bus_i.DRDY), 64'h1);
    check_eq("ord_dti", 64'(bus_i.DTi), 64'h1122_3344);
    check_eq("ord_err", 64'(err), 64'h0);

    // Spurious MDRDY after reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();
    check_eq("sp_err_clr", 64'(err), 64'h0);
    bus_i.MDRDY = 1'b1; bus_i.MDTI = 64'hDEAD_BEEF;
    step();
    bus_i.MDRDY = 1'b0;
    #1;
    check_eq("sp_drdy", 64'(bus_i.DRDY), 64'h0);
    check_eq("sp_err", 64'(err), 64'h1);
    step();
    check_eq("sp_err_sticky", 64'(err), 64'h1);

    // Reset with two reads pending
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();
    bus_i.ACT = 1'b1; bus_i.CMD = 1'b1; bus_i.SIZE = 2'b00; bus_i.ADDRESS = 45'h500;
    step();
    bus_i.ADDRESS = 45'h509;
    step();
    bus_i.ACT = 1'b0;
    step();
    check_eq("mid_idle", 64'(idle), 64'h0);
    check_eq("mid_mact", 64'(bus_i.MACT), 64'h1);
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    step();
    rst_n = 1'b1;
    step(); step();
    check_eq("post_idle", 64'(idle), 64'h1);
    bus_i.MDRDY = 1'b1;
    step();
    bus_i.MDRDY = 1'b0;
    #1;
    check_eq("post_err", 64'(err), 64'h1);
    check_eq("post_drdy", 64'(bus_i.DRDY), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_mem_bridge.md
Name: mcu_mem_bridge

Overview:
- Sits directly downstream of the microcontroller memory port (ACT/CMD/SIZE/ADDRESS/DTo, NEXT/DRDY/DTi).
- Converts 8/16/32-bit byte-addressed microcontroller accesses into 64-bit qword transactions with byte enables on the system memory bus.
- Buffers posted writes and reads in a request FIFO.
- Tracks outstanding reads in order and returns right-aligned, zero-extended read data.

Parameters:
- RQ_DEPTH, 4, request FIFO entries (power of 2, ≥2)
- RD_DEPTH, 4, maximum outstanding reads (power of 2, ≥2)

Ports:
- CLK  in  1  clock, all logic on posedge
- RESET  in  1  asynchronous active-low reset
- ACT  in  1  request valid from microcontroller
- CMD  in  1  1=read, 0=write
- SIZE  in  2  00 byte, 01 16-bit, 10 32-bit, 11 treated as 32-bit
- ADDRESS  in  45  byte address
- DTo  in  32  write data, right-aligned
- NEXT  out  1  request accepted this cycle when ACT&NEXT
- DRDY  out  1  one-cycle read data valid pulse
- DTi  out  32  read data, right-aligned, zero-extended
- MACT  out  1  memory bus request valid
- MCMD  out  1  1=read, 0=write
- MADDR  out  42  qword address (ADDRESS[44:3])
- MBE  out  8  byte enables
- MDTO  out  64  lane-positioned write data
- MNEXT  in  1  memory accepts request when MACT&MNEXT
- MDRDY  in  1  read return valid; returns are in order
- MDTI  in  64  read return data
- ERR  out  1  sticky: MDRDY received with no read outstanding
- IDLE  out  1  request FIFO empty and no reads outstanding

Behaviour:
- Reset values: NEXT=0, DRDY=0, DTi=0, MACT=0, MCMD=0, MADDR=0, MBE=0, MDTO=0, ERR=0, IDLE=1. Both FIFOs empty; outstanding count = 0. Reset mid-transfer drops all queued and outstanding transactions; a later MDRDY then sets ERR.
- NEXT is combinational: ~rq_full & (~CMD | rd_cnt_total < RD_DEPTH).
  - rd_cnt_total = reads queued in the request FIFO + reads issued and awaiting MDRDY.
  - Therefore no read is ever accepted without tracker space.
- Lane formation on accept:
  - off = ADDRESS[2:0], forced aligned per size: 16-bit clears bit0; 32-bit clears bits 1:0. No error is raised for misalignment.
  - MBE: byte = 1<<off; 16-bit = 2'b11<<off; 32-bit = 4'hF<<off.
  - MDTO = DTo lanes shifted left by 8*off; unused lanes are 0.
- Accepted entry {CMD, ADDRESS[44:3], MBE, MDTO} is pushed to the request FIFO.
- A read additionally pushes {SIZE, off} into the tracker FIFO at accept time. This preserves program order, because reads and writes share one FIFO.
- Memory side:
  - MACT=1 and the M* fields show the FIFO head whenever the FIFO is non-empty. They are driven from registered head state, so there is no comb path from ACT to MACT.
  - Pop occurs on MACT&MNEXT.
  - Fall-through latency: an accept in cycle N gives MACT=1 in cycle N+1 if the FIFO was empty.
- Simultaneous push and pop while full is not possible: NEXT=0 when full, even if a pop occurs that cycle.
- Read return:
  - On MDRDY with tracker non-empty: pop the tracker, then extract bytes starting at lane off and zero-extend per size.
  - DRDY=1 and DTi are registered in the cycle after MDRDY. DTi holds its value until the next return.
- MDRDY with tracker empty: data discarded, ERR set to 1 until reset.
- Back-to-back MDRDY every cycle is supported; DRDY then pulses every cycle.
- Simultaneous read accept and MDRDY: the tracker pushes and pops in the same cycle; the count is unchanged.
- IDLE = rq_empty & tracker_empty, registered.

Decomposition:
- Package mcu_bridge_pkg holds:
  - size enum SZ_B/SZ_W/SZ_D;
  - qword width constant (64), lane count (8);
  - function byte_en(size, off);
  - function extract(data64, size, off).
- Sub-module mcu_bridge_fifo: parameterised sync FIFO (WIDTH, DEPTH), async active-low reset, with push/pop/full/empty/count outputs.
  - Instantiated twice: request FIFO (1+42+8+64 bits) and read tracker (2+3 bits).

Test Plan:
- Write byte: ACT,CMD=0,SIZE=00,ADDRESS=0x...05,DTo=0xA5 → next cycle MACT=1, MCMD=0, MADDR=ADDRESS>>3, MBE=0x20, MDTO=0x0000A50000000000.
- Read 16-bit at off 6: MDRDY with MDTI=0x1234_5678_9ABC_DEF0 → DRDY one cycle later, DTi=0x00001234.
- Backpressure: MNEXT=0, issue RQ_DEPTH writes → NEXT=0 on the next ACT; raise MNEXT → pops one per cycle, NEXT reasserts after the first pop.
- Read limit: 4 reads outstanding, no MDRDY → NEXT=0 for reads, NEXT=1 for writes while the FIFO has space; one MDRDY → read accepted again.
- Ordering: write 0x11223344 to A then read A (32-bit) → memory sees the write before the read; the return is extracted at the correct off.
- Spurious MDRDY after reset → ERR=1 and no DRDY. Assert RESET with 2 reads pending → all outputs return to reset values and IDLE=1.
